// File: rtl/monster_spawn_ctrl.sv
// Spawn scheduler: counts frames, picks the lowest free monster slot and issues a
// one-cycle gene pulse with a pseudo-random start X and a start direction.
module monster_spawn_ctrl #(
  parameter int          NUM_SLOTS      = 4,
  parameter logic [9:0]  SPAWN_INTERVAL = 10'd240,
  parameter logic [9:0]  X_MIN          = 10'd170,
  parameter logic [9:0]  SPAWN_Y        = 10'd0,
  parameter logic [2:0]  ACK_FRAMES     = 3'd4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_frame_clk,
  input  logic                 i_enable,
  input  logic [1:0]           i_level,
  input  logic [NUM_SLOTS-1:0] i_slot_active,
  output logic [NUM_SLOTS-1:0] o_gene,
  output logic [9:0]           o_spawn_x,
  output logic [9:0]           o_spawn_y,
  output logic                 o_spawn_dir,
  output logic [7:0]           o_spawn_count,
  output logic                 o_no_ack_err
);

  localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_SEARCH,
    S_ISSUE,
    S_COOLDOWN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [9:0]       r_frame_cnt;
  logic [9:0]       w_frame_cnt_nxt;
  logic [2:0]       r_ack_cnt;
  logic [2:0]       w_ack_cnt_nxt;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] w_sel_nxt;
  logic [9:0]       r_spawn_x;
  logic [9:0]       w_spawn_x_nxt;
  logic             r_spawn_dir;
  logic             w_spawn_dir_nxt;
  logic [7:0]       r_spawn_count;
  logic [7:0]       w_spawn_count_nxt;
  logic             r_no_ack_err;
  logic             w_no_ack_err_nxt;
  logic [15:0]      r_lfsr;
  logic [15:0]      w_lfsr_nxt;

  logic [9:0]       w_thr_shift;
  logic [9:0]       w_thr;
  logic [10:0]      w_frame_inc;
  logic [2:0]       w_ack_inc;
  logic             w_free_found;
  logic [SEL_W-1:0] w_free_idx;

  // Free-running Galois LFSR, right-shifting with taps 16'hB400.
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  assign w_thr_shift = SPAWN_INTERVAL >> i_level;
  assign w_thr       = (w_thr_shift == 10'd0) ? 10'd1 : w_thr_shift;
  assign w_frame_inc = {1'b0, r_frame_cnt} + 11'd1;
  assign w_ack_inc   = r_ack_cnt + 3'd1;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!i_slot_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SEL_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_ack_cnt_nxt     = r_ack_cnt;
    w_sel_nxt         = r_sel;
    w_spawn_x_nxt     = r_spawn_x;
    w_spawn_dir_nxt   = r_spawn_dir;
    w_spawn_count_nxt = r_spawn_count;
    w_no_ack_err_nxt  = r_no_ack_err;

    case (r_state)
      S_IDLE: begin
        w_frame_cnt_nxt = '0;
        if (i_enable) w_state_nxt = S_COUNT;
      end
      S_COUNT: begin
        if (i_frame_clk) begin
          // >= rather than == so a lowered threshold fires on the next frame
          if (w_frame_inc >= {1'b0, w_thr}) begin
            w_frame_cnt_nxt = '0;
            w_state_nxt     = S_SEARCH;
          end else begin
            w_frame_cnt_nxt = w_frame_inc[9:0];
          end
        end
      end
      S_SEARCH: begin
        w_frame_cnt_nxt = '0;
        if (w_free_found && i_enable) begin
          w_sel_nxt       = w_free_idx;
          w_spawn_x_nxt   = X_MIN + {2'b00, r_lfsr[7:0]};
          w_spawn_dir_nxt = r_lfsr[15];
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_spawn_count != 8'hFF) w_spawn_count_nxt = r_spawn_count + 8'd1;
        w_ack_cnt_nxt = '0;
        w_state_nxt   = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        // An ack arriving with the final frame wins over the timeout.
        if (i_slot_active[r_sel]) begin
          w_state_nxt = S_COUNT;
        end else if (i_frame_clk) begin
          if (w_ack_inc == ACK_FRAMES) begin
            w_no_ack_err_nxt = 1'b1;
            w_state_nxt      = S_COUNT;
          end else begin
            w_ack_cnt_nxt = w_ack_inc;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (!i_enable) begin
      w_state_nxt     = S_IDLE;
      w_frame_cnt_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_frame_cnt   <= '0;
      r_ack_cnt     <= '0;
      r_sel         <= '0;
      r_spawn_x     <= X_MIN;
      r_spawn_dir   <= 1'b0;
      r_spawn_count <= '0;
      r_no_ack_err  <= 1'b0;
      r_lfsr        <= LFSR_SEED;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_ack_cnt     <= w_ack_cnt_nxt;
      r_sel         <= w_sel_nxt;
      r_spawn_x     <= w_spawn_x_nxt;
      r_spawn_dir   <= w_spawn_dir_nxt;
      r_spawn_count <= w_spawn_count_nxt;
      r_no_ack_err  <= w_no_ack_err_nxt;
      r_lfsr        <= w_lfsr_nxt;
    end
  end

  // Gene is decoded purely from registers so it cannot glitch on input changes.
  always_comb begin
    o_gene = '0;
    if (r_state == S_ISSUE) o_gene[r_sel] = 1'b1;
  end

  assign o_spawn_x     = r_spawn_x;
  assign o_spawn_y     = SPAWN_Y;
  assign o_spawn_dir   = r_spawn_dir;
  assign o_spawn_count = r_spawn_count;
  assign o_no_ack_err  = r_no_ack_err;

endmodule

// File: tb/tb_monster_spawn_ctrl.sv
// Directed bench for monster_spawn_ctrl: stimulus pushes expected gene pulses,
// a negedge monitor pops and checks gene, count, spawn_x and spawn_dir.
module tb_monster_spawn_ctrl;

  localparam logic [9:0]  X_MIN = 10'd170;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk;
  logic       rst;
  logic       frame;
  logic       en;
  logic [1:0] level;
  logic [3:0] slot_active;
  logic [3:0] gene;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic       spawn_dir;
  logic [7:0] spawn_count;
  logic       no_ack_err;

  monster_spawn_ctrl #(
    .NUM_SLOTS     (4),
    .SPAWN_INTERVAL(10'd8),
    .X_MIN         (X_MIN),
    .SPAWN_Y       (10'd0),
    .ACK_FRAMES    (3'd4),
    .LFSR_SEED     (SEED)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_frame_clk  (frame),
    .i_enable     (en),
    .i_level      (level),
    .i_slot_active(slot_active),
    .o_gene       (gene),
    .o_spawn_x    (spawn_x),
    .o_spawn_y    (spawn_y),
    .o_spawn_dir  (spawn_dir),
    .o_spawn_count(spawn_count),
    .o_no_ack_err (no_ack_err)
  );

  typedef struct {
    logic [3:0] gene;
    logic [7:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          exp_cnt  = 0;
  int          n_seen   = 0;
  int          x_changes = 0;
  logic [9:0]  first_x;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] galois(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR; m_prev holds the value the DUT sampled in the previous cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= galois(m_lfsr);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic [3:0] g);
    exp_t e;
    e.gene = g;
    e.cnt  = 8'(exp_cnt);
    sb_q.push_back(e);
  endtask

  task automatic bump_cnt();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  // Returns the negedge index (1-based) at which gene was seen, 0 on timeout.
  task automatic wait_gene(output int pos);
    pos = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (gene != 4'b0000) begin
        pos = i;
        break;
      end
    end
  endtask

  task automatic spawn_cycle(input int n_frames, input logic [3:0] g, input logic rel);
    int pos;
    push_exp(g);
    repeat (n_frames - 1) pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    wait_gene(pos);
    chk("spawn_latency", 16'(pos), 16'd2);
    slot_active = slot_active | g;
    tick();
    tick();
    if (rel) slot_active = slot_active & ~g;
    bump_cnt();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gene"},  16'(gene),        16'h0);
    chk({tag, "_x"},     16'(spawn_x),     16'(X_MIN));
    chk({tag, "_y"},     16'(spawn_y),     16'h0);
    chk({tag, "_dir"},   16'(spawn_dir),   16'h0);
    chk({tag, "_count"}, 16'(spawn_count), 16'h0);
    chk({tag, "_err"},   16'(no_ack_err),  16'h0);
  endtask

  // Monitor: every gene pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    logic [9:0] ex_x;
    forever begin
      @(negedge clk);
      if (!rst && gene != 4'b0000) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_gene actual=%b expected=none at %0t", gene, $time);
        end else begin
          e = sb_q.pop_front();
          ex_x = X_MIN + {2'b00, m_prev[7:0]};
          chk("mon_gene",  16'(gene),        16'(e.gene));
          chk("mon_count", 16'(spawn_count), 16'(e.cnt));
          chk("mon_x",     16'(spawn_x),     16'(ex_x));
          chk("mon_dir",   16'(spawn_dir),   16'(m_prev[15]));
          chk("mon_y",     16'(spawn_y),     16'h0);
          if (n_seen == 0) first_x = spawn_x;
          else if (spawn_x != first_x) x_changes++;
          n_seen++;
        end
      end
    end
  end

  initial begin
    int pos;
    rst = 1'b1;
    frame = 1'b0;
    en = 1'b0;
    level = 2'd0;
    slot_active = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Basic spawn at level 0 (thr=8) into an empty pool
    en = 1'b1;
    tick();
    spawn_cycle(8, 4'b0001, 1'b0);
    chk("count_after_first", 16'(spawn_count), 16'd1);

    // Lowest free slot, then deferral while the pool is full
    slot_active = 4'b1011;
    spawn_cycle(8, 4'b0100, 1'b0);
    chk("full_pool", 16'(slot_active), 16'hF);
    repeat (8) pulse();
    repeat (4) tick();
    chk("defer_count", 16'(spawn_count), 16'(exp_cnt));
    push_exp(4'b0010);
    slot_active = 4'b1101;
    wait_gene(pos);
    chk("release_latency", 16'(pos), 16'd2);
    slot_active = 4'b1111;
    tick();
    tick();
    bump_cnt();
    // A full interval is needed again: frame_cnt restarted from 0
    slot_active = 4'b1110;
    spawn_cycle(8, 4'b0001, 1'b1);

    // Fast difficulty: thr=1 then thr=2
    slot_active = 4'b0000;
    level = 2'd3;
    repeat (3) spawn_cycle(1, 4'b0001, 1'b1);
    level = 2'd2;
    repeat (2) spawn_cycle(2, 4'b0001, 1'b1);
    level = 2'd3;

    // Ack on the same cycle as the final timeout frame: no error
    push_exp(4'b0001);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    wait_gene(pos);
    chk("ack_race_latency", 16'(pos), 16'd2);
    tick();
    bump_cnt();
    repeat (3) pulse();
    frame = 1'b1;
    slot_active = 4'b0001;
    tick();
    frame = 1'b0;
    tick();
    chk("ack_race_err", 16'(no_ack_err), 16'd0);
    slot_active = 4'b0000;

    // Missing ack: error after the 4th frame in cooldown
    push_exp(4'b0001);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    wait_gene(pos);
    chk("noack_latency", 16'(pos), 16'd2);
    tick();
    bump_cnt();
    repeat (3) pulse();
    chk("noack_err_early", 16'(no_ack_err), 16'd0);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    chk("noack_err_set", 16'(no_ack_err), 16'd1);
    tick();
    spawn_cycle(1, 4'b0001, 1'b1);
    chk("err_sticky", 16'(no_ack_err), 16'd1);

    // Reset during cooldown
    push_exp(4'b0001);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    wait_gene(pos);
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    exp_cnt = 0;
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Enable dropped in SEARCH: the spawn is discarded
    frame = 1'b1;
    tick();
    frame = 1'b0;
    en = 1'b0;
    repeat (3) tick();
    repeat (2) pulse();
    chk("en_drop_search_cnt", 16'(spawn_count), 16'(exp_cnt));
    en = 1'b1;
    tick();

    // Enable dropped during ISSUE: that pulse completes, then IDLE
    push_exp(4'b0001);
    frame = 1'b1;
    tick();
    frame = 1'b0;
    wait_gene(pos);
    chk("en_drop_issue_latency", 16'(pos), 16'd2);
    en = 1'b0;
    tick();
    bump_cnt();
    chk("en_drop_issue_cnt", 16'(spawn_count), 16'(exp_cnt));
    repeat (2) pulse();
    chk("en_drop_idle_cnt", 16'(spawn_count), 16'(exp_cnt));
    en = 1'b1;
    tick();

    // Saturation of the spawn counter
    repeat (260) spawn_cycle(1, 4'b0001, 1'b1);
    chk("count_saturated", 16'(spawn_count), 16'd255);
    chk("x_varies", 16'(x_changes > 0), 16'd1);
    chk("sb_drained", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monster_spawn_ctrl.md
Name: monster_spawn_ctrl

Overview:
Scheduler that decides when and where new monsters enter the playfield. It shares a fixed pool of monster sprite instances (slots) between spawn requests. It counts frames, picks the lowest free slot from the slots' appear flags, and issues a one-cycle gene pulse to that slot. The pulse carries a pseudo-random start X and a start direction. It sits between the game-state logic (enable, difficulty) and the array of monster instances.

Parameters:
NUM_SLOTS, 4, number of monster instances managed (1..8)
SPAWN_INTERVAL, 10'd240, frames between spawns at difficulty level 0
X_MIN, 10'd170, left playfield edge; spawn_x lower bound
SPAWN_Y, 10'd0, Y coordinate given to every spawned monster
ACK_FRAMES, 3'd4, frames to wait for the slot's appear flag after gene
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
frame_clk  input  1  one-Clk-cycle pulse per video frame, synchronous to Clk
enable  input  1  game running; low forces IDLE
level  input  2  difficulty; interval = SPAWN_INTERVAL >> level, minimum 1
slot_active  input  NUM_SLOTS  appear flag from each monster slot
gene  output  NUM_SLOTS  one-hot spawn pulse, 1 Clk wide
spawn_x  output  10  start X for the spawned slot
spawn_y  output  10  start Y (= SPAWN_Y)
spawn_dir  output  1  start direction: 0 = left, 1 = right
spawn_count  output  8  total spawns issued, saturates at 255
no_ack_err  output  1  sticky flag: a slot failed to raise appear within ACK_FRAMES

Behaviour:
- Reset (async, active-high) sets:
  - state = IDLE, frame_cnt = 0, ack_cnt = 0, sel = 0.
  - gene = 0, spawn_x = X_MIN, spawn_y = SPAWN_Y, spawn_dir = 0.
  - spawn_count = 0, no_ack_err = 0, lfsr = LFSR_SEED.
- LFSR: 16-bit Galois, mask 16'hB400. Advances every Clk cycle when not in reset, independent of state.
- Threshold thr = SPAWN_INTERVAL >> level. If the result is 0, thr = 1. Sampled every cycle, so a level change takes effect immediately.
- State IDLE:
  - gene = 0 and frame_cnt held at 0.
  - enable=1 -> COUNT on the next cycle.
- State COUNT:
  - On frame_clk: if frame_cnt+1 >= thr, set frame_cnt <= 0 and go to SEARCH. Otherwise frame_cnt <= frame_cnt+1.
  - frame_cnt is 10 bits wide and never wraps: the compare uses >=, so a lowered thr fires on the next frame.
- State SEARCH:
  - If any bit of slot_active is 0: latch sel = lowest-index zero bit.
  - In the same cycle, latch spawn_x = X_MIN + lfsr[7:0] and spawn_dir = lfsr[15], then go to ISSUE.
  - Integration constraint: X_MIN + 255 + monster width must stay ≤ the right edge.
  - If all slots are active: stay in SEARCH (spawn deferred, not dropped). frame_cnt stays 0.
- State ISSUE (exactly one cycle):
  - gene = one-hot(sel), decoded from registered state and sel only (glitch-free).
  - spawn_count increments, saturating at 255.
  - Set ack_cnt = 0, then go to COOLDOWN.
- State COOLDOWN:
  - If slot_active[sel]=1 -> COUNT (acknowledged).
  - Otherwise, on frame_clk ack_cnt increments. When ack_cnt+1 == ACK_FRAMES: set no_ack_err = 1 and go to COUNT.
  - If the ack and the final frame_clk arrive in the same cycle, the ack wins: no error.
- spawn_x, spawn_y and spawn_dir hold their values from SEARCH until the next SEARCH latch.
- enable=0 in any state -> IDLE on the next edge, with frame_cnt = 0. The pending spawn is discarded.
  - Exception: if enable falls during ISSUE, gene is still asserted for that ISSUE cycle. COOLDOWN is then skipped and the next state is IDLE.
- no_ack_err clears only on Reset.
- Latency: a frame_clk that reaches thr at edge t gives SEARCH at t+1 and ISSUE (gene high) during cycle t+2, provided a slot is free.

Test Plan:
- SPAWN_INTERVAL=8, level=0, enable=1, slot_active=4'b0000, 8 frame_clk pulses -> gene=4'b0001 for exactly one cycle, 2 cycles after the 8th pulse; spawn_count=1; spawn_x in 170..425.
- Same setup, slot_active=4'b1011 -> gene=4'b0100. Then set slot_active=4'b1111 before the next threshold -> no gene. Release bit 1 -> gene=4'b0010 on the 2nd cycle after release; frame_cnt=0.
- SPAWN_INTERVAL=8, level=3 -> thr=1, gene on every frame while slots ack. level=2 -> one gene per 2 frames.
- Never raise the slot_active ack, ACK_FRAMES=4 -> no_ack_err=1 after the 4th frame_clk in COOLDOWN and state returns to COUNT. Ack on the same cycle as the 4th pulse -> no_ack_err stays 0.
- Assert Reset mid-COOLDOWN, and separately drop enable in SEARCH -> all outputs at reset values immediately on Reset; gene never asserted after enable drops. Drop enable during the ISSUE cycle -> that one gene pulse completes, then IDLE.
- Issue 260 spawns with fast acks -> spawn_count saturates at 255. LFSR output across spawns is nonconstant and never reaches the all-zero state.
